// File: rtl/piton_local_port_arbiter.sv
// Round-robin arbiter sharing one router LOCAL injection port between NREQ requesters,
// with wormhole packet locking and credit (yummy) flow control.

module piton_local_port_arbiter_lane #(
    parameter int IDW  = 2,
    parameter int LANE = 0
) (
    input  logic           valid,
    input  logic           idle,
    input  logic [IDW-1:0] grant_id,
    output logic           eligible
);
    // Outside a packet anyone may compete; inside one only the lock owner.
    assign eligible = valid && (idle || (grant_id == IDW'(LANE)));
endmodule

module piton_local_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 64,
    parameter int CREDITS = 4,
    parameter int LEN_LSB = 22,
    parameter int LEN_W   = 8,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = (CREDITS > 0) ? $clog2(CREDITS + 1) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     yummy_in,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic [CW-1:0]            credit_cnt,
    output logic                     credit_err
);
    typedef enum logic {IDLE, BODY} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr, rr_ptr_nxt, grant_nxt, winner;
    logic [LEN_W-1:0]  remaining, remaining_nxt, hdr_len;
    logic [NREQ-1:0]   eligible;
    logic [DATA_W-1:0] win_data;
    logic              found, send;

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
        return (int'(x) >= NREQ - 1) ? '0 : x + 1'b1;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        piton_local_port_arbiter_lane #(.IDW(IDW), .LANE(i)) u_lane (
            .valid    (req_valid[i]),
            .idle     (state == IDLE),
            .grant_id (grant_id),
            .eligible (eligible[i])
        );
    end

    // In BODY only the owner is eligible, so the same scan serves both states.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                winner   = IDW'(idx);
                win_data = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign send    = found && (credit_cnt != '0) && !reset;
    assign hdr_len = win_data[LEN_LSB +: LEN_W];
    assign busy    = (state == BODY);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = send && (winner == IDW'(i));
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        remaining_nxt = remaining;
        grant_nxt     = grant_id;
        if (send) begin
            case (state)
                IDLE: begin
                    if (hdr_len == '0) begin
                        rr_ptr_nxt = inc_wrap(winner);
                    end else begin
                        state_nxt     = BODY;
                        remaining_nxt = hdr_len;
                        grant_nxt     = winner;
                    end
                end
                BODY: begin
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = inc_wrap(grant_id);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            remaining  <= '0;
            grant_id   <= '0;
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            remaining <= remaining_nxt;
            grant_id  <= grant_nxt;
            valid_out <= send;
            if (send) data_out <= win_data;
            // A yummy with no room left is a router protocol error; saturate and flag it.
            if (send && !yummy_in) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (!send && yummy_in) begin
                if (credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
                else                            credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piton_local_port_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random traffic
// compared against a packet-level reference model.

module tb_piton_local_port_arbiter;
    localparam int NREQ = 4, DATA_W = 64, CREDITS = 4, LEN_LSB = 22, LEN_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset, valid_out, yummy_in, busy, credit_err;
    logic [NREQ-1:0]        req_valid, req_ready;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]      data_out;
    logic [1:0]             grant_id;
    logic [2:0]             credit_cnt;

    piton_local_port_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CREDITS(CREDITS),
                               .LEN_LSB(LEN_LSB), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .data_out(data_out), .valid_out(valid_out),
        .yummy_in(yummy_in), .grant_id(grant_id), .busy(busy),
        .credit_cnt(credit_cnt), .credit_err(credit_err));

    // Stimulus state
    logic [DATA_W-1:0] flit [NREQ];
    logic [NREQ-1:0]   vld;
    logic              y, rst;
    logic [NREQ-1:0]   got_ready;
    int                last_pick;
    int                nerr = 0, nchk = 0;

    // Packet-level reference model
    bit          m_inpkt, m_err, m_vout;
    int          m_owner, m_left, m_rr, m_cred;
    logic [63:0] m_dout;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        int         len;
        logic       y;
        logic [3:0] exp_rdy;
        logic       exp_vout;
        int         exp_id;
        int         exp_cred;
        logic       exp_busy;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input int id, input int len, input int seq);
        logic [63:0] f;
        f = '0;
        f[63:56] = 8'(id);
        f[55:40] = 16'(seq);
        f[LEN_LSB +: LEN_W] = LEN_W'(len);
        return f;
    endfunction

    function automatic int pick();
        if (rst || m_cred == 0) return -1;
        if (m_inpkt) return vld[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_rr + k) % NREQ;
            if (vld[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_inpkt = 0; m_err = 0; m_vout = 0; m_owner = 0; m_left = 0;
        m_rr = 0; m_cred = CREDITS; m_dout = '0;
    endfunction

    function automatic void model_update(input int p);
        bit s;
        int l;
        if (rst) begin
            model_reset();
            return;
        end
        s = (p >= 0);
        m_vout = s;
        if (s) begin
            m_dout = flit[p];
            if (!m_inpkt) begin
                l = int'(flit[p][LEN_LSB +: LEN_W]);
                if (l == 0) m_rr = (p + 1) % NREQ;
                else begin m_inpkt = 1; m_owner = p; m_left = l; end
            end else begin
                m_left--;
                if (m_left == 0) begin m_inpkt = 0; m_rr = (m_owner + 1) % NREQ; end
            end
        end
        if (s && !y) m_cred--;
        else if (!s && y) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred++;
        end
    endfunction

    task automatic tick();
        int p;
        logic [NREQ-1:0] er;
        for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = flit[i];
        req_valid = vld; yummy_in = y; reset = rst;
        #1;
        p  = pick();
        er = (p >= 0) ? NREQ'(1) << p : '0;
        got_ready = req_ready;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        model_update(p);
        #1;
        chk("valid_out", valid_out, m_vout);
        chk("data_out", data_out, m_dout);
        chk("credit_cnt", credit_cnt, m_cred);
        chk("credit_err", credit_err, m_err);
        chk("busy", busy, m_inpkt);
        if (m_inpkt) chk("grant_id", grant_id, m_owner);
        last_pick = p;
    endtask

    task automatic do_reset();
        rst = 1; vld = '0; y = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        int s1, s2;
        int due [$];
        model_reset();
        rst = 1; vld = '0; y = 0; last_pick = -1;
        for (int i = 0; i < NREQ; i++) flit[i] = '0;
        req_data = '0; req_valid = '0; yummy_in = 0; reset = 1;
        @(posedge clk); #1;

        // Single-flit packets from requester 2, then returns; two locked len=2 packets
        tbl[0]  = '{1'b1, 4'b0000, 0, 1'b0, 4'b0000, 1'b0, 0, 4, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 0, 1'b0, 4'b0100, 1'b1, 2, 3, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 0, 1'b0, 4'b0100, 1'b1, 2, 2, 1'b0};
        tbl[3]  = '{1'b0, 4'b0100, 0, 1'b0, 4'b0100, 1'b1, 2, 1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 0, 1'b1, 4'b0000, 1'b0, 0, 2, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 0, 1'b1, 4'b0000, 1'b0, 0, 3, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 0, 1'b1, 4'b0000, 1'b0, 0, 4, 1'b0};
        tbl[7]  = '{1'b0, 4'b0011, 2, 1'b1, 4'b0001, 1'b1, 0, 4, 1'b1};
        tbl[8]  = '{1'b0, 4'b0011, 2, 1'b1, 4'b0001, 1'b1, 0, 4, 1'b1};
        tbl[9]  = '{1'b0, 4'b0011, 2, 1'b1, 4'b0001, 1'b1, 0, 4, 1'b0};
        tbl[10] = '{1'b0, 4'b0010, 2, 1'b1, 4'b0010, 1'b1, 1, 4, 1'b1};
        tbl[11] = '{1'b0, 4'b0010, 2, 1'b1, 4'b0010, 1'b1, 1, 4, 1'b1};
        tbl[12] = '{1'b0, 4'b0010, 2, 1'b1, 4'b0010, 1'b1, 1, 4, 1'b0};
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; vld = tbl[i].vld; y = tbl[i].y;
            for (int j = 0; j < NREQ; j++) flit[j] = mk(j, tbl[i].len, 0);
            tick();
            chk("tbl_ready", got_ready, tbl[i].exp_rdy);
            chk("tbl_vout", valid_out, tbl[i].exp_vout);
            if (tbl[i].exp_vout) chk("tbl_id", data_out[63:56], tbl[i].exp_id);
            chk("tbl_cred", credit_cnt, tbl[i].exp_cred);
            chk("tbl_busy", busy, tbl[i].exp_busy);
        end
        // rr pointer should now sit at 2
        vld = 4'b1111; y = 0;
        for (int j = 0; j < NREQ; j++) flit[j] = mk(j, 0, 9);
        tick();
        chk("rr_after_pkt", got_ready, 4'b0100);

        // Credit exhaustion mid-packet, then a single returned credit
        do_reset();
        flit[3] = mk(3, 5, 1); vld = 4'b1000; y = 0;
        repeat (4) tick();
        tick();
        chk("starved_ready", got_ready, 4'b0000);
        chk("starved_cred", credit_cnt, 0);
        y = 1; tick();
        chk("yummy_no_bypass", got_ready, 4'b0000);
        chk("one_credit", credit_cnt, 1);
        y = 0; tick();
        chk("one_more_flit", got_ready, 4'b1000);
        tick();
        chk("stall_again", got_ready, 4'b0000);

        // Coincident yummy/send and overflow
        do_reset();
        flit[0] = mk(0, 0, 2); vld = 4'b0001; y = 0;
        repeat (3) tick();
        y = 1; tick();
        chk("send_and_yummy", credit_cnt, 1);
        vld = '0;
        repeat (3) tick();
        chk("refilled", credit_cnt, 4);
        tick();
        chk("overflow_sat", credit_cnt, 4);
        chk("overflow_err", credit_err, 1);
        y = 0; repeat (3) tick();
        chk("err_sticky", credit_err, 1);
        do_reset();
        chk("err_cleared", credit_err, 0);

        // Reset in the middle of a packet
        flit[0] = mk(0, 5, 3); vld = 4'b0001; y = 0;
        repeat (3) tick();
        rst = 1; tick();
        chk("ready_in_reset", got_ready, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_cred", credit_cnt, 4);
        chk("rst_vout", valid_out, 0);
        rst = 0; vld = 4'b0010; flit[1] = mk(1, 0, 4);
        tick();
        chk("post_rst_hdr", got_ready, 4'b0010);
        chk("post_rst_id", data_out[63:56], 1);

        // Round-robin fairness with yummy = send delayed by 2
        do_reset();
        vld = 4'b1111;
        for (int j = 0; j < NREQ; j++) flit[j] = mk(j, 0, 5);
        s1 = 0; s2 = 0;
        for (int k = 0; k < 12; k++) begin
            logic [3:0] e;
            e = 4'(1 << (k % 4));
            y = s2[0];
            tick();
            chk("rr_fair", got_ready, e);
            s2 = s1;
            s1 = (last_pick >= 0) ? 1 : 0;
        end

        // Random traffic with a router that returns credits after 1..4 cycles
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int j = 0; j < NREQ; j++) begin
                int l;
                vld[j] = ($urandom_range(0, 3) != 0);
                l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                flit[j] = mk(j, l, n) ^ {8'h0, 8'($urandom), 48'h0};
            end
            y = 0;
            for (int q = 0; q < due.size(); q++) begin
                if (due[q] <= n) begin
                    due.delete(q);
                    y = 1;
                    break;
                end
            end
            if (!y) y = ($urandom_range(0, 99) == 0);
            tick();
            if (rst) due.delete();
            else if (last_pick >= 0) due.push_back(n + $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
